// File: rtl/image_gen_pkg.sv
// image_gen_pkg: ILI9341 opcodes, RGB565 palettes, FSM states and the init/header command ROM.
// Constants only; no latency, no backpressure.
package image_gen_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  localparam int unsigned INIT_DELAY_DEF = 5000;
  localparam int unsigned CELL_DEF       = 20;
  localparam int unsigned GRID_W         = 16;
  localparam int unsigned GRID_H         = 12;

  localparam logic [15:0] P0_HEAD   = 16'h07E0;
  localparam logic [15:0] P0_BODY   = 16'h03E0;
  localparam logic [15:0] P0_APPLE  = 16'hF800;
  localparam logic [15:0] P0_BORDER = 16'hFFFF;
  localparam logic [15:0] P0_BG     = 16'h0000;
  localparam logic [15:0] P1_HEAD   = 16'hFFE0;
  localparam logic [15:0] P1_BODY   = 16'hFD20;
  localparam logic [15:0] P1_APPLE  = 16'hF800;
  localparam logic [15:0] P1_BORDER = 16'h001F;
  localparam logic [15:0] P1_BG     = 16'h2104;
  localparam logic [15:0] C_GAMEOVER = 16'hF800;
  localparam logic [15:0] C_GRID     = 16'h4208;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_HEADER,
    ST_PIXELS,
    ST_FRAME_END
  } state_t;

  // Entries are {dcx, byte}; the first INIT_LEN run once, the rest open every frame.
  localparam int unsigned INIT_LEN = 7;
  localparam int unsigned ROM_LEN  = 18;
  localparam logic [8:0] CMD_ROM [ROM_LEN] = '{
    {1'b0, OP_SWRESET}, {1'b0, OP_SLPOUT},
    {1'b0, OP_COLMOD},  {1'b1, 8'h55},
    {1'b0, OP_MADCTL},  {1'b1, 8'h28},
    {1'b0, OP_DISPON},
    {1'b0, OP_CASET},   {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, 8'h01}, {1'b1, 8'h3F},
    {1'b0, OP_PASET},   {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, 8'hEF},
    {1'b0, OP_RAMWR}
  };

  function automatic logic [15:0] pal_colour(input logic pal, input logic [15:0] c0,
                                             input logic [15:0] c1);
    return pal ? c1 : c0;
  endfunction

endpackage

// File: rtl/image_generator_lcd_byte_writer.sv
// lcd_byte_writer: 8080 write strobe, cycle A drives D/dcx with wr low, cycle B raises wr.
// Latency: byte on the bus the cycle after i_start; o_ready high in cycle B allows back-to-back bytes.
module lcd_byte_writer (
  input  logic       clk,
  input  logic       nrst,
  input  logic       i_start,
  input  logic       i_dcx,
  input  logic [7:0] i_dat,
  output logic       o_ready,
  output logic       o_wr,
  output logic       o_dcx,
  output logic [7:0] o_d
);

  logic       r_wr;
  logic       r_dcx;
  logic [7:0] r_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr  <= 1'b1;
      r_dcx <= 1'b1;
      r_d   <= 8'h00;
    end else if (i_start && r_wr) begin
      r_wr  <= 1'b0;
      r_dcx <= i_dcx;
      r_d   <= i_dat;
    end else begin
      r_wr  <= 1'b1;
    end
  end

  assign o_ready = r_wr;
  assign o_wr    = r_wr;
  assign o_dcx   = r_dcx;
  assign o_d     = r_d;

endmodule

// File: rtl/image_generator.sv
// image_generator: ILI9341 init then endless 16x12-cell RGB565 snake frames; GRID_LINES_EN adds grid lines.
// Latency: one byte per 2 clk, no stalls, no backpressure; frame period 22 + 4*H_PIX*V_PIX cycles.
module image_generator
  import image_gen_pkg::*;
#(
  parameter int unsigned INIT_DELAY = INIT_DELAY_DEF,
  parameter int unsigned CELL       = CELL_DEF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       snakeHead,
  input  logic       snakeBody,
  input  logic       apple,
  input  logic       border,
  input  logic       KeyEnc,
  input  logic       GameOver,
  output logic       sync,
  output logic       dcx,
  output logic       wr,
  output logic [7:0] D,
  output logic [3:0] x,
  output logic [3:0] y
);

  localparam logic [4:0]  SUB_LAST   = 5'(CELL - 1);
  localparam logic [3:0]  X_LAST     = 4'(GRID_W - 1);
  localparam logic [3:0]  Y_LAST     = 4'(GRID_H - 1);
  localparam logic [4:0]  IDX_INIT_L = 5'(INIT_LEN - 1);
  localparam logic [4:0]  IDX_HDR_F  = 5'(INIT_LEN);
  localparam logic [4:0]  IDX_HDR_L  = 5'(ROM_LEN - 1);
  localparam logic [15:0] DELAY_LOAD = 16'(INIT_DELAY + 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [15:0] r_delay;
  logic        r_lo, w_lo_nxt;
  logic [7:0]  r_colour_lo;
  logic [4:0]  r_sub_x, r_sub_y;
  logic [3:0]  r_x, r_y;
  logic        r_sync, w_sync_nxt;
  logic        r_key_d, r_pend, r_pal, r_go;

  logic        w_ready, w_start, w_dcx;
  logic [7:0]  w_dat;
  logic [8:0]  w_rom;
  logic [15:0] w_colour;
  logic        w_delay_load, w_adv, w_colour_ld, w_frame_latch, w_cnt_clr;
  logic        w_key_rise, w_last_px;

  assign w_rom      = CMD_ROM[r_idx];
  assign w_key_rise = KeyEnc & ~r_key_d;
  assign w_last_px  = (r_sub_x == SUB_LAST) && (r_x == X_LAST) &&
                      (r_sub_y == SUB_LAST) && (r_y == Y_LAST);

  // Later assignments win, so the order below encodes the colour priority.
  always_comb begin
    w_colour = pal_colour(r_pal, P0_BG, P1_BG);
    if (border)    w_colour = pal_colour(r_pal, P0_BORDER, P1_BORDER);
    if (apple)     w_colour = pal_colour(r_pal, P0_APPLE, P1_APPLE);
    if (snakeBody) w_colour = pal_colour(r_pal, P0_BODY, P1_BODY);
    if (snakeHead) w_colour = pal_colour(r_pal, P0_HEAD, P1_HEAD);
    if (r_go && !border) w_colour = C_GAMEOVER;
`ifdef GRID_LINES_EN
    if (!border && (r_sub_x == 5'd0 || r_sub_y == 5'd0)) w_colour = C_GRID;
`endif
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_lo_nxt      = r_lo;
    w_start       = 1'b0;
    w_dcx         = 1'b1;
    w_dat         = 8'h00;
    w_delay_load  = 1'b0;
    w_adv         = 1'b0;
    w_colour_ld   = 1'b0;
    w_frame_latch = 1'b0;
    w_sync_nxt    = 1'b0;
    w_cnt_clr     = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_ready && r_delay == 16'd0) begin
          w_start      = 1'b1;
          {w_dcx, w_dat} = w_rom;
          w_idx_nxt    = r_idx + 5'd1;
          w_delay_load = (r_idx <= 5'd1);
          if (r_idx == IDX_INIT_L) w_state_nxt = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (w_ready) begin
          w_start        = 1'b1;
          {w_dcx, w_dat} = w_rom;
          if (r_idx == IDX_HDR_L) begin
            w_idx_nxt     = IDX_HDR_F;
            w_frame_latch = 1'b1;
            w_state_nxt   = ST_PIXELS;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end
      ST_PIXELS: begin
        if (w_ready) begin
          w_start  = 1'b1;
          w_lo_nxt = ~r_lo;
          if (!r_lo) begin
            w_dat       = w_colour[15:8];
            w_colour_ld = 1'b1;
          end else begin
            w_dat = r_colour_lo;
            w_adv = 1'b1;
            if (w_last_px) w_state_nxt = ST_FRAME_END;
          end
        end
      end
      ST_FRAME_END: begin
        w_sync_nxt  = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_HEADER;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_INIT;
      r_idx       <= 5'd0;
      r_delay     <= 16'd0;
      r_lo        <= 1'b0;
      r_colour_lo <= 8'h00;
      r_sync      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_lo    <= w_lo_nxt;
      r_sync  <= w_sync_nxt;
      if (w_delay_load)        r_delay <= DELAY_LOAD;
      else if (r_delay != 0)   r_delay <= r_delay - 16'd1;
      if (w_colour_ld)         r_colour_lo <= w_colour[7:0];
    end
  end

  // Palette and game-over change only at RAMWR so a frame is never torn.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_key_d <= 1'b0;
      r_pend  <= 1'b0;
      r_pal   <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_key_d <= KeyEnc;
      if (w_frame_latch) begin
        r_pal  <= r_pal ^ r_pend;
        r_go   <= GameOver;
        r_pend <= w_key_rise;
      end else begin
        r_pend <= r_pend | w_key_rise;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sub_x <= 5'd0;
      r_sub_y <= 5'd0;
      r_x     <= 4'd0;
      r_y     <= 4'd0;
    end else if (w_cnt_clr) begin
      r_sub_x <= 5'd0;
      r_sub_y <= 5'd0;
      r_x     <= 4'd0;
      r_y     <= 4'd0;
    end else if (w_adv) begin
      if (r_sub_x == SUB_LAST) begin
        r_sub_x <= 5'd0;
        if (r_x == X_LAST) begin
          r_x <= 4'd0;
          if (r_sub_y == SUB_LAST) begin
            r_sub_y <= 5'd0;
            r_y     <= (r_y == Y_LAST) ? 4'd0 : r_y + 4'd1;
          end else begin
            r_sub_y <= r_sub_y + 5'd1;
          end
        end else begin
          r_x <= r_x + 4'd1;
        end
      end else begin
        r_sub_x <= r_sub_x + 5'd1;
      end
    end
  end

  lcd_byte_writer u_writer (
    .clk     (clk),
    .nrst    (nrst),
    .i_start (w_start),
    .i_dcx   (w_dcx),
    .i_dat   (w_dat),
    .o_ready (w_ready),
    .o_wr    (wr),
    .o_dcx   (dcx),
    .o_d     (D)
  );

  assign sync = r_sync;
  assign x    = r_x;
  assign y    = r_y;

endmodule

// File: tb/tb_image_generator.sv
// Scoreboard bench for image_generator: expected {dcx,byte} stream queued per frame, popped per wr strobe.
// Frame size is scaled down via CELL so three frames plus init fit in a short run.
module tb_image_generator;

  localparam int INIT_DELAY = 5000;
  localparam int CELL       = 4;
  localparam int H          = 16 * CELL;
  localparam int V          = 12 * CELL;
  localparam int PIX_BYTES  = 2 * H * V;
  localparam int PERIOD     = 22 + 2 * PIX_BYTES;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       KeyEnc = 1'b0;
  logic       GameOver = 1'b0;
  logic       snakeHead, snakeBody, apple, border;
  logic       sync, dcx, wr;
  logic [7:0] D;
  logic [3:0] x, y;

  always #5 clk = ~clk;

  // Game-logic model answering on the current cell.
  assign border    = (x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd11);
  assign snakeHead = (x == 4'd4) && (y == 4'd4);
  assign snakeBody = (y == 4'd4) && ((x == 4'd2) || (x == 4'd3));
  assign apple     = ((x == 4'd7) && (y == 4'd4)) || ((x == 4'd10) && (y == 4'd11));

  image_generator #(.INIT_DELAY(INIT_DELAY), .CELL(CELL)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .snakeHead (snakeHead),
    .snakeBody (snakeBody),
    .apple     (apple),
    .border    (border),
    .KeyEnc    (KeyEnc),
    .GameOver  (GameOver),
    .sync      (sync),
    .dcx       (dcx),
    .wr        (wr),
    .D         (D),
    .x         (x),
    .y         (y)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];
  int cyc = 0;
  int byte_idx = 0, c_swreset = 0, c_slpout = 0, c_caset = 0;
  int pix_bytes = 0, ramwr_cnt = 0, sync_cnt = 0, last_sync = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [8:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  function automatic logic [15:0] model_colour(input int cx, input int cy, input bit pal, input bit go);
    bit b;
    b = (cx == 0) || (cx == 15) || (cy == 0) || (cy == 11);
    if (go && !b) return 16'hF800;
    if (cx == 4 && cy == 4) return pal ? 16'hFFE0 : 16'h07E0;
    if (cy == 4 && (cx == 2 || cx == 3)) return pal ? 16'hFD20 : 16'h03E0;
    if ((cx == 7 && cy == 4) || (cx == 10 && cy == 11)) return 16'hF800;
    if (b) return pal ? 16'h001F : 16'hFFFF;
    return pal ? 16'h2104 : 16'h0000;
  endfunction

  task automatic push_frame(input int f, input bit pal, input bit go);
    logic [8:0]  hdr [11];
    logic [15:0] c;
    hdr = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
            9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};
    for (int i = 0; i < 11; i++) push($sformatf("f%0d_hdr%0d", f, i), hdr[i]);
    for (int py = 0; py < V; py++) begin
      for (int px = 0; px < H; px++) begin
        c = model_colour(px / CELL, py / CELL, pal, go);
        push($sformatf("f%0d_px(%0d,%0d)_hi", f, px, py), {1'b1, c[15:8]});
        push($sformatf("f%0d_px(%0d,%0d)_lo", f, px, py), {1'b1, c[7:0]});
      end
    end
  endtask

  task automatic wait_mid(input int f, input string tag);
    for (int i = 0; i < 40000 && !(ramwr_cnt == f && pix_bytes >= PIX_BYTES / 2); i++)
      @(posedge clk);
    check(tag, (ramwr_cnt == f && pix_bytes >= PIX_BYTES / 2), 1);
  endtask

  task automatic pulse_key();
    #1 KeyEnc = 1'b1;
    @(posedge clk);
    #1 KeyEnc = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_wr"},   wr,   1);
    check({pfx, "_dcx"},  dcx,  1);
    check({pfx, "_D"},    D,    0);
    check({pfx, "_x"},    x,    0);
    check({pfx, "_y"},    y,    0);
    check({pfx, "_sync"}, sync, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Byte and sync monitor, sampling mid-cycle.
  initial begin
    logic [8:0] ev;
    string      t;
    logic       prev_wr, prev_sync;
    prev_wr   = 1'b1;
    prev_sync = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (!wr) begin
          check("wr_low_one_cycle", prev_wr, 1);
          if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            t  = tag_q.pop_front();
            check(t, {dcx, D}, ev);
          end
          if (byte_idx == 0) c_swreset = cyc;
          if (byte_idx == 1) c_slpout  = cyc;
          if (byte_idx == 7) c_caset   = cyc;
          byte_idx++;
          if ({dcx, D} == 9'h02C) begin
            pix_bytes = 0;
            ramwr_cnt++;
          end else begin
            pix_bytes++;
          end
        end
        if (sync) begin
          check("sync_width", prev_sync, 0);
          check("sync_pix_bytes", pix_bytes, PIX_BYTES);
          check("sync_xy", {x, y}, 0);
          if (last_sync >= 0) check("sync_period", cyc - last_sync, PERIOD);
          last_sync = cyc;
          sync_cnt++;
        end
      end
      prev_wr   = wr;
      prev_sync = sync;
    end
  end

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    push("init_swreset", 9'h001);
    push("init_slpout",  9'h011);
    push("init_colmod",  9'h03A);
    push("init_colmod_d", 9'h155);
    push("init_madctl",  9'h036);
    push("init_madctl_d", 9'h128);
    push("init_dispon",  9'h029);
    push_frame(1, 1'b0, 1'b0);
    push_frame(2, 1'b1, 1'b0);
    push_frame(3, 1'b1, 1'b1);
    nrst = 1'b1;

    wait_mid(1, "reach_frame1_mid");
    pulse_key();
    repeat (5) @(posedge clk);
    pulse_key();

    wait_mid(2, "reach_frame2_mid");
    #1 GameOver = 1'b1;

    for (int i = 0; i < 40000 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    for (int i = 0; i < 100 && sync_cnt < 3; i++) @(posedge clk);
    check("sync_count", sync_cnt, 3);
    check("init_gap", c_slpout - c_swreset, INIT_DELAY + 2);
    check("init_len", c_caset - c_swreset, 2 * INIT_DELAY + 14);

    @(posedge clk);
    #1 nrst = 1'b0;
    GameOver = 1'b0;
    exp_q.delete();
    tag_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    push("restart_swreset", 9'h001);
    push("restart_slpout",  9'h011);
    nrst = 1'b1;
    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
    check("restart_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
